// File: rtl/seq_logic_arbiter_pkg.sv
// Shared types for seq_logic_arbiter: FSM state encoding, error counter ceiling, id width helper.
// Optional feature macro used across the slice: SEQ_LOGIC_ARBITER_ERRCNT_EN.
package seq_logic_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        HOLD  = 2'd2,
        CHECK = 2'd3
    } arb_state_t;

    localparam int ERRCNT_MAX = 255;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seq_logic_arbiter_if.sv
// Requester / seq_logic side bus of the arbiter; slave modport is the arbiter's view.
// err_count exists only when SEQ_LOGIC_ARBITER_ERRCNT_EN is defined.
interface seq_logic_arbiter_if #(
    parameter int N_REQ = 4
);
    localparam int ID_W = seq_logic_arb_pkg::id_width(N_REQ);

    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] req_data;
    logic [N_REQ-1:0] grant;
    logic             a_out;
    logic             sel_out;
    logic             f_in;
    logic             done;
    logic [ID_W-1:0]  done_id;
    logic             done_ok;
    logic             busy;
`ifdef SEQ_LOGIC_ARBITER_ERRCNT_EN
    logic [7:0]       err_count;
`endif

    modport master (
`ifdef SEQ_LOGIC_ARBITER_ERRCNT_EN
        input  err_count,
`endif
        output req, req_data, f_in,
        input  grant, a_out, sel_out, done, done_id, done_ok, busy
    );

    modport slave (
`ifdef SEQ_LOGIC_ARBITER_ERRCNT_EN
        output err_count,
`endif
        input  req, req_data, f_in,
        output grant, a_out, sel_out, done, done_id, done_ok, busy
    );

endinterface

// File: rtl/seq_logic_arbiter_rr_pick.sv
// Combinational round-robin pick: first set request at or after the pointer, wrapping.
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [ID_W-1:0]  i_ptr,
    output logic [N_REQ-1:0] o_onehot,
    output logic [ID_W-1:0]  o_idx,
    output logic             o_valid
);

    int              w_j;
    logic [ID_W-1:0] w_jdx;

    // Scan from the farthest offset down so the nearest one to the pointer wins.
    always_comb begin
        o_onehot = '0;
        o_idx    = '0;
        o_valid  = 1'b0;
        w_j      = 0;
        w_jdx    = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            w_j   = (int'(i_ptr) + k) % N_REQ;
            w_jdx = ID_W'(w_j);
            if (i_req[w_jdx]) begin
                o_idx   = w_jdx;
                o_valid = 1'b1;
            end
        end
        if (o_valid) o_onehot[o_idx] = 1'b1;
    end

endmodule

// File: rtl/seq_logic_arbiter.sv
// Round-robin owner of one seq_logic bit: load winner's bit, hold, read back, report.
// Optional saturating failure counter under SEQ_LOGIC_ARBITER_ERRCNT_EN.
module seq_logic_arbiter
    import seq_logic_arb_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int HOLD_CYCLES = 2
) (
    input  logic                CLK,
    input  logic                RST,
    seq_logic_arbiter_if.slave  bus
);

    localparam int ID_W = id_width(N_REQ);

    arb_state_t       r_state, w_next;
    logic [ID_W-1:0]  r_ptr, r_id, w_win_id, r_done_id;
    logic [N_REQ-1:0] w_win_oh, w_grant, r_grant;
    logic             w_win_vld, w_arb, r_bit;
    logic             w_sel, w_a, r_sel, r_a;
    logic             r_done, r_done_ok, r_busy;
    logic [7:0]       r_cnt;

    rr_pick #(.N_REQ(N_REQ), .ID_W(ID_W)) u_pick (
        .i_req    (bus.req),
        .i_ptr    (r_ptr),
        .o_onehot (w_win_oh),
        .o_idx    (w_win_id),
        .o_valid  (w_win_vld)
    );

    // CHECK doubles as an arbitration slot so a new LOAD can overlap done.
    assign w_arb = w_win_vld && (r_state == IDLE || r_state == CHECK);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_arb) w_next = LOAD;
            LOAD:    w_next = (HOLD_CYCLES > 0) ? HOLD : CHECK;
            HOLD:    if (r_cnt == '0) w_next = CHECK;
            CHECK:   w_next = w_arb ? LOAD : IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        w_grant = w_arb ? w_win_oh : '0;
        w_sel   = w_arb;
        w_a     = w_arb && bus.req_data[w_win_id];
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_ptr     <= '0;
            r_id      <= '0;
            r_bit     <= 1'b0;
            r_cnt     <= '0;
            r_grant   <= '0;
            r_sel     <= 1'b0;
            r_a       <= 1'b0;
            r_done    <= 1'b0;
            r_done_id <= '0;
            r_done_ok <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            if (w_arb) begin
                r_ptr <= (w_win_id == ID_W'(N_REQ - 1)) ? '0 : w_win_id + 1'b1;
                r_id  <= w_win_id;
                r_bit <= bus.req_data[w_win_id];
            end
            if (r_state == LOAD)
                r_cnt <= (HOLD_CYCLES > 0) ? 8'(HOLD_CYCLES - 1) : 8'd0;
            else if (r_state == HOLD && r_cnt != '0)
                r_cnt <= r_cnt - 1'b1;
            r_grant <= w_grant;
            r_sel   <= w_sel;
            r_a     <= w_a;
            r_busy  <= (w_next != IDLE);
            r_done  <= (r_state == CHECK);
            if (r_state == CHECK) begin
                r_done_id <= r_id;
                r_done_ok <= (bus.f_in == r_bit);
            end
        end
    end

`ifdef SEQ_LOGIC_ARBITER_ERRCNT_EN
    logic [7:0] r_err;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            r_err <= '0;
        else if (r_state == CHECK && bus.f_in != r_bit && r_err != 8'(ERRCNT_MAX))
            r_err <= r_err + 1'b1;
    end

    assign bus.err_count = r_err;
`endif

    assign bus.grant   = r_grant;
    assign bus.sel_out = r_sel;
    assign bus.a_out   = r_a;
    assign bus.done    = r_done;
    assign bus.done_id = r_done_id;
    assign bus.done_ok = r_done_ok;
    assign bus.busy    = r_busy;

endmodule

// File: tb/tb_seq_logic_arbiter.sv
// Scoreboard bench for seq_logic_arbiter: transaction-level reference model feeds expectation
// queues, a negedge monitor compares. Second instance (HOLD_CYCLES=0, F stuck at 0) covers failures.
module tb_seq_logic_arbiter;

    localparam int N = 4;
    localparam int H = 2;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    seq_logic_arbiter_if #(.N_REQ(N)) bus ();
    seq_logic_arbiter_if #(.N_REQ(N)) bus2 ();

    seq_logic_arbiter #(.N_REQ(N), .HOLD_CYCLES(H)) dut (.CLK(CLK), .RST(RST), .bus(bus));
    seq_logic_arbiter #(.N_REQ(N), .HOLD_CYCLES(0)) dut2 (.CLK(CLK), .RST(RST), .bus(bus2));

    // seq_logic register, optionally corrupted per transaction by the model
    logic r_f = 1'b0;
    logic r_corrupt = 1'b0;
    always @(posedge CLK) if (bus.sel_out) r_f <= bus.a_out;
    assign bus.f_in  = r_f ^ r_corrupt;
    assign bus2.f_in = 1'b0;

    typedef struct { int cyc; int id; logic bitv; } gexp_t;
    typedef struct { int cyc; int id; logic ok; }   dexp_t;
    gexp_t gq[$];
    dexp_t dq[$];

    int         cyc = 0, timer = 0, ptr = 0, m_id = 0;
    int         tests = 0, fails = 0, exp_err = 0, t5_n = 0;
    logic       exp_busy = 1'b0, corrupt_en = 1'b0, hold_req = 1'b0, t5_on = 1'b0, m_c = 1'b0;
    logic [N-1:0] granted_now = '0;

    // Reference model: one transaction occupies the register for 2+H edges after its grant.
    always @(posedge CLK) begin
        cyc++;
        granted_now = '0;
        if (RST) begin
            timer = 0;
            ptr   = 0;
            gq.delete();
            dq.delete();
            exp_busy = 1'b0;
        end else begin
            if (timer > 0) timer--;
            if (timer == 0 && bus.req != '0) begin
                m_id = -1;
                for (int k = 0; k < N; k++)
                    if (m_id < 0 && bus.req[(ptr + k) % N]) m_id = (ptr + k) % N;
                ptr = (m_id + 1) % N;
                m_c = corrupt_en && ($urandom_range(0, 3) == 0);
                gq.push_back(gexp_t'{cyc, m_id, bus.req_data[m_id]});
                dq.push_back(dexp_t'{cyc + 2 + H, m_id, !m_c});
                r_corrupt <= m_c;
                granted_now[m_id] = 1'b1;
                timer = 2 + H;
            end
            exp_busy = (timer != 0);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    logic [N-1:0] mon_g;
    logic         mon_s, mon_a;

    always @(negedge CLK) begin
        mon_g = '0;
        mon_s = 1'b0;
        mon_a = 1'b0;
        if (gq.size() > 0 && gq[0].cyc == cyc) begin
            mon_g[gq[0].id] = 1'b1;
            mon_s = 1'b1;
            mon_a = gq[0].bitv;
            void'(gq.pop_front());
        end
        chk("grant", 32'(bus.grant), 32'(mon_g));
        chk("sel_out", 32'(bus.sel_out), 32'(mon_s));
        chk("a_out", 32'(bus.a_out), 32'(mon_a));
        if (dq.size() > 0 && dq[0].cyc == cyc) begin
            chk("done", 32'(bus.done), 32'd1);
            chk("done_id", 32'(bus.done_id), 32'(dq[0].id));
            chk("done_ok", 32'(bus.done_ok), 32'(dq[0].ok));
            if (!dq[0].ok && exp_err < 255) exp_err++;
            void'(dq.pop_front());
        end else begin
            chk("done", 32'(bus.done), 32'd0);
        end
        chk("busy", 32'(bus.busy), 32'(exp_busy));
        if (RST) begin
            exp_err = 0;
            chk("rst_done_id", 32'(bus.done_id), 32'd0);
            chk("rst_done_ok", 32'(bus.done_ok), 32'd0);
        end
`ifdef SEQ_LOGIC_ARBITER_ERRCNT_EN
        chk("err_count", 32'(bus.err_count), 32'(exp_err));
`endif
        // stuck-at-0 readback instance, req=0001 held: LOAD/CHECK alternate from cycle 1
        if (t5_on) begin
            t5_n++;
            chk("t5_grant", 32'(bus2.grant), (t5_n % 2 == 1) ? 32'd1 : 32'd0);
            chk("t5_sel", 32'(bus2.sel_out), (t5_n % 2 == 1) ? 32'd1 : 32'd0);
            chk("t5_done", 32'(bus2.done), (t5_n >= 3 && t5_n % 2 == 1) ? 32'd1 : 32'd0);
            if (t5_n >= 3 && t5_n % 2 == 1) begin
                chk("t5_done_ok", 32'(bus2.done_ok), 32'd0);
                chk("t5_done_id", 32'(bus2.done_id), 32'd0);
            end
            chk("t5_busy", 32'(bus2.busy), 32'd1);
`ifdef SEQ_LOGIC_ARBITER_ERRCNT_EN
            chk("t5_err_count", 32'(bus2.err_count),
                32'(((t5_n - 1) / 2 > 255) ? 255 : (t5_n - 1) / 2));
`endif
        end
    end

    // Inputs change mid-low-phase; granted requesters drop unless hold_req.
    task automatic tick();
        @(negedge CLK);
        #2;
        if (!hold_req) bus.req = bus.req & ~granted_now;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((exp_busy || gq.size() > 0 || dq.size() > 0) && n < 200) begin
            tick();
            n++;
        end
        tests++;
        if (n >= 200) begin
            fails++;
            $display("FAIL wait_idle: got busy after %0d cycles expected idle", n);
        end
    endtask

    initial begin
        bus.req = '0;  bus.req_data = '0;
        bus2.req = '0; bus2.req_data = '0;
        repeat (3) tick();
        RST = 1'b0;

        // single request, bit 1 stored in requester 2
        tick();
        bus.req = 4'b0100; bus.req_data = 4'b0100;
        tick();
        bus.req_data = '0;
        wait_idle();

        // pointer at 3: wrap to requester 0, then pointer 1 picks requester 2
        bus.req = 4'b0101; bus.req_data = 4'b0001;
        wait_idle();

        // reset during HOLD aborts, then re-request
        bus.req = 4'b0001; bus.req_data = 4'b0001;
        tick();
        tick();
        RST = 1'b1;
        repeat (2) tick();
        RST = 1'b0;
        wait_idle();

        // all request continuously
        hold_req = 1'b1;
        bus.req = 4'b1111; bus.req_data = 4'b1010;
        repeat (5 * (2 + H)) tick();
        hold_req = 1'b0;
        bus.req = '0;
        wait_idle();

        // request withdrawn while another transaction is loading
        bus.req = 4'b0001; bus.req_data = 4'b0011;
        tick();
        bus.req = 4'b0010;
        tick();
        bus.req = '0;
        wait_idle();

        // random traffic with occasional readback corruption
        corrupt_en = 1'b1;
        repeat (1500) begin
            int r;
            tick();
            r = int'($urandom_range(0, 63));
            if (r % 4 == 0)  bus.req[$urandom_range(0, N - 1)] = 1'b1;
            if (r % 16 == 1) bus.req[$urandom_range(0, N - 1)] = 1'b0;
            bus.req_data = N'($urandom);
        end
        bus.req = '0;
        wait_idle();
        corrupt_en = 1'b0;

        // HOLD_CYCLES=0 instance with F stuck at 0
        bus2.req = 4'b0001; bus2.req_data = 4'b0001;
        t5_on = 1'b1;
        repeat (605) @(negedge CLK);
        #2;
        t5_on = 1'b0;
        bus2.req = '0;
        repeat (4) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
